// File: rtl/cache_types.sv
// Shared types and width helpers for the N-way write-back cache.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cache_types;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int off_w(input int line_bytes);
        return clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int num_sets);
        return clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int num_sets);
        return addr_w - off_w(line_bytes) - idx_w(num_sets);
    endfunction

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: next tree bits for an access and the current victim way.
// Latency: purely combinational.
// Backpressure: none.
module plru_tree
    import cache_types::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]        bits_in,
    input  logic [clog2(NUM_WAYS)-1:0] access_way,
    output logic [NUM_WAYS-2:0]        bits_out,
    output logic [clog2(NUM_WAYS)-1:0] victim
);
    localparam int WAY_W = clog2(NUM_WAYS);

    // Each node on the accessed path is pointed at the opposite half.
    always_comb begin : upd
        logic [WAY_W-1:0] node;
        node     = '0;
        bits_out = bits_in;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            bits_out[node] = ~access_way[WAY_W-1-lvl];
            node = WAY_W'(2 * int'(node) + 1 + int'(access_way[WAY_W-1-lvl]));
        end
    end

    always_comb begin : walk
        logic [WAY_W-1:0] node;
        node   = '0;
        victim = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = bits_in[node];
            node = WAY_W'(2 * int'(node) + 1 + int'(bits_in[node]));
        end
    end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU; CACHE_STATS_EN adds hit/miss counters.
// Latency: hits respond in the request cycle; misses respond one cycle after the last mem_resp.
// Backpressure: CPU request is held until cpu_resp; memory requests are held until mem_resp.
module nway_wb_cache
    import cache_types::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 8,
    parameter int NUM_WAYS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic [ADDR_W-1:0]       cpu_address,
    input  logic [LINE_BYTES-1:0]   cpu_sel,
    input  logic [8*LINE_BYTES-1:0] cpu_wdata,
    output logic [8*LINE_BYTES-1:0] cpu_rdata,
    output logic                    cpu_resp,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic [8*LINE_BYTES-1:0] mem_rdata,
    input  logic                    mem_resp
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(NUM_SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, NUM_SETS);
    localparam int WAY_W  = clog2(NUM_WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;

    cache_state_t state_q, state_d;

    logic [LINE_W-1:0]   data_arr [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q   [NUM_SETS];
    logic [WAY_W-1:0]    victim_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic                req;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic                any_inv;
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    miss_victim;
    logic [WAY_W-1:0]    plru_access;
    logic [NUM_WAYS-2:0] plru_next;
    logic                hit_upd;
    logic                fill_done;
    logic                miss_start;
    logic                unused_off;

    assign idx        = cpu_address[OFF_W +: IDX_W];
    assign req_tag    = cpu_address[ADDR_W-1 -: TAG_W];
    assign req        = cpu_read | cpu_write;
    assign unused_off = ^cpu_address[OFF_W-1:0];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_arr[idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end
    assign hit = |hit_vec;

    // Scan downwards so the lowest-index invalid way wins.
    always_comb begin
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_way = WAY_W'(w);
                any_inv = 1'b1;
            end
        end
    end

    assign plru_access = (state_q == FILL) ? victim_q : hit_way;
    assign miss_victim = any_inv ? inv_way : plru_victim;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits_in    (plru_q[idx]),
        .access_way (plru_access),
        .bits_out   (plru_next),
        .victim     (plru_victim)
    );

    assign cpu_rdata  = data_arr[idx][hit_way];
    assign hit_upd    = (state_q == IDLE) && req && hit;
    assign miss_start = (state_q == IDLE) && req && !hit;
    assign fill_done  = (state_q == FILL) && mem_resp;

    always_comb begin
        state_d     = state_q;
        cpu_resp    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    cpu_resp = 1'b1;
                end else if (req) begin
                    state_d = (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim])
                              ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_arr[idx][victim_q], idx, {OFF_W{1'b0}}};
                mem_wdata   = data_arr[idx][victim_q];
                if (mem_resp) state_d = FILL;
            end
            FILL: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, idx, {OFF_W{1'b0}}};
                if (mem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (miss_start) victim_q <= miss_victim;
            if (hit_upd) begin
                plru_q[idx] <= plru_next;
                if (cpu_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
                plru_q[idx]            <= plru_next;
            end
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (hit_upd && cpu_write) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (cpu_sel[b]) data_arr[idx][hit_way][8*b +: 8] <= cpu_wdata[8*b +: 8];
            end
        end
        if (fill_done) begin
            data_arr[idx][victim_q] <= mem_rdata;
            tag_arr[idx][victim_q]  <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic missed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            missed_q   <= 1'b0;
        end else begin
            if (miss_start) begin
                missed_q <= 1'b1;
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
            if (cpu_resp) begin
                missed_q <= 1'b0;
                if (!missed_q && hit_count != '1) hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nway_wb_cache.sv
// Directed scoreboard bench for nway_wb_cache with a behavioural next-level memory.
module tb_nway_wb_cache;

    logic         clk;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [15:0]  cpu_address;
    logic [15:0]  cpu_sel;
    logic [127:0] cpu_wdata;
    logic [127:0] cpu_rdata;
    logic         cpu_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [127:0] sb_q[$];
    logic [127:0] mem_img [logic [15:0]];
    logic [127:0] golden  [logic [15:0]];
    logic [127:0] last_wb_data;

    nway_wb_cache dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_sel     (cpu_sel),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_resp    (cpu_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [15:0] a);
        return {8{a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    function automatic logic [127:0] img_get(input logic [15:0] la);
        if (mem_img.exists(la)) return mem_img[la];
        return pattern(la);
    endfunction

    function automatic logic [127:0] golden_get(input logic [15:0] la);
        if (golden.exists(la)) return golden[la];
        return img_get(la);
    endfunction

    task automatic golden_merge(input logic [15:0] la, input logic [15:0] sel, input logic [127:0] wd);
        logic [127:0] line;
        line = golden_get(la);
        for (int b = 0; b < 16; b++) begin
            if (sel[b]) line[8*b +: 8] = wd[8*b +: 8];
        end
        golden[la] = line;
    endtask

    task automatic mem_pulse(inout int cyc);
        repeat (2) begin
            @(posedge clk); #1; cyc++;
        end
        mem_resp = 1'b1;
        @(posedge clk); #1; cyc++;
        mem_resp = 1'b0;
    endtask

    // One CPU request: memory traffic is served and checked until cpu_resp, then the request is dropped.
    task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] sel,
                          input logic [127:0] wd, input bit exp_hit, input bit exp_wb,
                          input logic [15:0] exp_wb_addr);
        logic [15:0] la;
        int  cyc;
        bit  done;
        bit  saw_wb;
        bit  saw_fill;
        la = addr & 16'hFFF0;
        cyc = 0; done = 0; saw_wb = 0; saw_fill = 0;
        cpu_read    = !wr;
        cpu_write   = wr;
        cpu_address = addr;
        cpu_sel     = sel;
        cpu_wdata   = wd;
        if (!wr) sb_q.push_back(golden_get(la));
        else     golden_merge(la, sel, wd);
        #1;
        chk("resp_in_req_cycle", cpu_resp, exp_hit);
        while (!done && cyc < 60) begin
            if (cpu_resp) begin
                if (exp_hit) chk("hit_latency", cyc, 0);
                else         chk("fill_before_resp", saw_fill, 1);
                chk("resp_mem_idle", {mem_read, mem_write}, 2'b00);
                if (!wr) chk("rdata", cpu_rdata, sb_q.pop_front());
                done = 1;
            end else if (mem_write) begin
                chk("wb_addr", mem_address, exp_wb_addr);
                chk("wb_data", mem_wdata, golden_get(mem_address));
                chk("wb_no_read", mem_read, 0);
                last_wb_data = mem_wdata;
                mem_img[mem_address] = mem_wdata;
                saw_wb = 1;
                mem_pulse(cyc);
            end else if (mem_read) begin
                chk("fill_addr", mem_address, la);
                mem_rdata = img_get(la);
                saw_fill = 1;
                mem_pulse(cyc);
                chk("miss_latency", cpu_resp, 1);
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        chk("req_done", done, 1);
        chk("wb_seen", saw_wb, exp_wb);
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_sel = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0; last_wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_resp", cpu_resp, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_address, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss then hit on the same line.
        access(0, 16'h1230, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1234, 16'h0, '0, 1, 0, 16'h0);
`ifdef CACHE_STATS_EN
        chk("stat_hits", hit_count, 1);
        chk("stat_misses", miss_count, 1);
`endif

        // Byte-merging write hit makes way 0 dirty; fill the rest of set 3.
        access(1, 16'h1230, 16'h0003, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1, 0, 16'h0);
        access(0, 16'h12B0, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1330, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h13B0, 16'h0, '0, 0, 0, 16'h0);
        // PLRU points at way 0 (0x1230, dirty): write-back carries the merged bytes.
        access(0, 16'h1430, 16'h0, '0, 0, 1, 16'h1230);
        chk("wb_beef_bytes", last_wb_data[15:0], 16'hBEEF);
        chk("wb_upper_kept", last_wb_data[127:16], pattern(16'h1230) >> 16);
        // Next victim is way 2 (clean 0x1330); 0x1230 comes back from memory merged.
        access(0, 16'h1230, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1330, 16'h0, '0, 0, 0, 16'h0);

        // PLRU order from a clean reset.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        access(0, 16'h1230, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h12B0, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1330, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h13B0, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1230, 16'h0, '0, 1, 0, 16'h0);
        access(0, 16'h1430, 16'h0, '0, 0, 0, 16'h0);
        access(0, 16'h1230, 16'h0, '0, 1, 0, 16'h0);
        access(0, 16'h12B0, 16'h0, '0, 1, 0, 16'h0);
        access(0, 16'h13B0, 16'h0, '0, 1, 0, 16'h0);
        access(0, 16'h1330, 16'h0, '0, 0, 0, 16'h0);

        // Reset asserted mid-fill drops mem_read at once and the line stays invalid.
        cpu_read = 1'b1; cpu_address = 16'h1630;
        cyc = 0;
        #1;
        while (!mem_read && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("midfill_req", mem_read, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_async_mem_read", mem_read, 0);
        chk("rst_async_mem_addr", mem_address, 0);
        chk("rst_async_resp", cpu_resp, 0);
        cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        access(0, 16'h1630, 16'h0, '0, 0, 0, 16'h0);

        // Write miss allocates, then merges on the re-lookup hit.
        access(1, 16'h1730, 16'h8000, 128'h7700_0000_0000_0000_0000_0000_0000_00AA, 0, 0, 16'h0);
        access(0, 16'h1730, 16'h0, '0, 1, 0, 16'h0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
